// File: rtl/frog_pkg.sv
// Shared constants, state encoding and lane-array type for the frog collision block.
package frog_pkg;

  localparam int ROWS      = 8;
  localparam int COLS      = 16;
  localparam int START_COL = 7;
  localparam int GOAL_ROW  = 7;
  localparam int MOVES_MAX = 255;

  typedef enum logic [1:0] {
    ALIVE = 2'd0,
    HIT   = 2'd1,
    WIN   = 2'd2
  } frog_state_t;

  typedef logic [ROWS-1:0][COLS-1:0] lane_t;

  // Rows 0 and GOAL_ROW are safe; only the rows in between carry cars.
  function automatic logic is_lane_row(input logic [2:0] row);
    return (row != 3'd0) && (row != 3'(GOAL_ROW));
  endfunction

endpackage

// File: rtl/frog_collision_if.sv
// Key inputs, lane pixels and frog status outputs of the frog collision block.
interface frog_collision_if;
  logic              key_up;
  logic              key_down;
  logic              key_left;
  logic              key_right;
  frog_pkg::lane_t   lane_pixels;
  logic [2:0]        frog_row;
  logic [3:0]        frog_col;
  frog_pkg::lane_t   frog_pixels;
  logic              hit;
  logic              win;
  logic [7:0]        moves;
  frog_pkg::frog_state_t state;

  // Keys are level inputs with no handshake: each 0->1 transition is one move
  // request, sampled on posedge clk; all outputs are stable between edges.
  modport master (
    output key_up, key_down, key_left, key_right, lane_pixels,
    input  frog_row, frog_col, frog_pixels, hit, win, moves, state
  );

  modport slave (
    input  key_up, key_down, key_left, key_right, lane_pixels,
    output frog_row, frog_col, frog_pixels, hit, win, moves, state
  );
endinterface

// File: rtl/frog_collision_edge_detect.sv
// Rising-edge detector: one-cycle pulse after a registered 0->1 transition.
module edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic pulse
);

  logic cur;
  logic prev;

  // History resets to "pressed" so a key held across reset must be released first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur  <= 1'b1;
      prev <= 1'b1;
    end else begin
      cur  <= din;
      prev <= cur;
    end
  end

  assign pulse = cur & ~prev;

endmodule

// File: rtl/frog_collision.sv
// Frog position, move handling, collision detection and board overlay.
module frog_collision
  import frog_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  frog_collision_if.slave bus
);

  localparam logic [2:0] GOAL_R  = 3'(GOAL_ROW);
  localparam logic [3:0] START_C = 4'(START_COL);
  localparam logic [3:0] MAX_C   = 4'(COLS - 1);
  localparam logic [7:0] MAX_MV  = 8'(MOVES_MAX);

  logic req_up, req_down, req_left, req_right;

  edge_detect u_ed_up    (.clk(clk), .reset(reset), .din(bus.key_up),    .pulse(req_up));
  edge_detect u_ed_down  (.clk(clk), .reset(reset), .din(bus.key_down),  .pulse(req_down));
  edge_detect u_ed_left  (.clk(clk), .reset(reset), .din(bus.key_left),  .pulse(req_left));
  edge_detect u_ed_right (.clk(clk), .reset(reset), .din(bus.key_right), .pulse(req_right));

  frog_state_t state, state_n;
  logic [2:0]  row_q, row_n;
  logic [3:0]  col_q, col_n;
  logic [7:0]  moves_q, moves_n;
  logic        car_here;
  logic        move_ok;
  lane_t       overlay;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ALIVE;
      row_q   <= 3'd0;
      col_q   <= START_C;
      moves_q <= 8'd0;
    end else begin
      state   <= state_n;
      row_q   <= row_n;
      col_q   <= col_n;
      moves_q <= moves_n;
    end
  end

  assign car_here = bus.lane_pixels[row_q][col_q] & is_lane_row(row_q);

  // Priority picks one request; a clamped winner is ignored and the rest are dropped.
  always_comb begin
    state_n = state;
    row_n   = row_q;
    col_n   = col_q;
    moves_n = moves_q;
    move_ok = 1'b0;
    case (state)
      ALIVE: begin
        if (car_here) begin
          state_n = HIT;
        end else if (req_up) begin
          if (row_q != GOAL_R) begin
            row_n   = row_q + 3'd1;
            move_ok = 1'b1;
            if (row_q == GOAL_R - 3'd1) state_n = WIN;
          end
        end else if (req_down) begin
          if (row_q != 3'd0) begin
            row_n   = row_q - 3'd1;
            move_ok = 1'b1;
          end
        end else if (req_left) begin
          if (col_q != MAX_C) begin
            col_n   = col_q + 4'd1;
            move_ok = 1'b1;
          end
        end else if (req_right) begin
          if (col_q != 4'd0) begin
            col_n   = col_q - 4'd1;
            move_ok = 1'b1;
          end
        end
        if (move_ok && (moves_q != MAX_MV)) moves_n = moves_q + 8'd1;
      end
      HIT:     state_n = HIT;
      WIN:     state_n = WIN;
      default: state_n = ALIVE;
    endcase
  end

  always_comb begin
    overlay               = '0;
    overlay[row_q][col_q] = 1'b1;
  end

  assign bus.frog_row    = row_q;
  assign bus.frog_col    = col_q;
  assign bus.frog_pixels = overlay;
  assign bus.hit         = (state == HIT);
  assign bus.win         = (state == WIN);
  assign bus.moves       = moves_q;
  assign bus.state       = state;

endmodule

// File: tb/tb_frog_collision.sv
// Bench for frog_collision: vector table, directed corner cases, random walks vs. a press-level model.
module tb_frog_collision;
  import frog_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  frog_collision_if fif ();

  frog_collision dut (
    .clk   (clk),
    .reset (reset),
    .bus   (fif)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Expected frog status; the bench's press-level reference model.
  int m_row, m_col, m_moves;
  bit m_hit, m_win;
  lane_t m_lane;

  typedef struct {
    logic [3:0] keys;   // {up, down, left, right}
    int         row;
    int         col;
    int         mv;
    bit         w;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_keys(input logic [3:0] k);
    fif.key_up    = k[3];
    fif.key_down  = k[2];
    fif.key_left  = k[1];
    fif.key_right = k[0];
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_keys(4'b0000);
    fif.lane_pixels = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    m_row = 0; m_col = START_COL; m_moves = 0; m_hit = 0; m_win = 0;
    m_lane = '0;
  endtask

  // Full key press and release; any resulting move and collision have settled on return.
  task automatic press(input logic [3:0] k);
    set_keys(k);
    tick();
    tick();
    set_keys(4'b0000);
    tick();
    tick();
  endtask

  // Reference: one press = one decision taken from the game rules.
  task automatic model_press(input logic [3:0] k);
    bit acc;
    acc = 0;
    if (!m_hit && !m_win) begin
      if (k[3]) begin
        if (m_row < GOAL_ROW) begin m_row++; acc = 1; end
      end else if (k[2]) begin
        if (m_row > 0) begin m_row--; acc = 1; end
      end else if (k[1]) begin
        if (m_col < COLS - 1) begin m_col++; acc = 1; end
      end else if (k[0]) begin
        if (m_col > 0) begin m_col--; acc = 1; end
      end
      if (acc && m_moves < MOVES_MAX) m_moves++;
      if (m_row == GOAL_ROW) m_win = 1;
      else if (m_row >= 1 && m_row <= 6 && m_lane[m_row][m_col]) m_hit = 1;
    end
  endtask

  task automatic chk_model(input string tag);
    lane_t e;
    e = '0;
    e[m_row][m_col] = 1'b1;
    chk({tag, ".row"},   128'(fif.frog_row),    128'(m_row));
    chk({tag, ".col"},   128'(fif.frog_col),    128'(m_col));
    chk({tag, ".moves"}, 128'(fif.moves),       128'(m_moves));
    chk({tag, ".hit"},   128'(fif.hit),         128'(m_hit));
    chk({tag, ".win"},   128'(fif.win),         128'(m_win));
    chk({tag, ".pix"},   128'(fif.frog_pixels), 128'(e));
  endtask

  task automatic chk_reset_vals(input string tag);
    lane_t e;
    e = '0;
    e[0] = 16'h0080;
    chk({tag, ".row"},   128'(fif.frog_row),    128'd0);
    chk({tag, ".col"},   128'(fif.frog_col),    128'd7);
    chk({tag, ".moves"}, 128'(fif.moves),       128'd0);
    chk({tag, ".hit"},   128'(fif.hit),         128'd0);
    chk({tag, ".win"},   128'(fif.win),         128'd0);
    chk({tag, ".pix"},   128'(fif.frog_pixels), 128'(e));
  endtask

  initial begin
    reset = 1'b1;
    set_keys(4'b0000);
    fif.lane_pixels = '0;
    #3;
    chk_reset_vals("reset_async");

    // ---------------- vector table: mixed walk on empty lanes ----------------
    vecs.push_back('{4'b1000, 1, 7, 1, 0});
    vecs.push_back('{4'b0010, 1, 8, 2, 0});
    vecs.push_back('{4'b0010, 1, 9, 3, 0});
    vecs.push_back('{4'b0001, 1, 8, 4, 0});
    vecs.push_back('{4'b0100, 0, 8, 5, 0});
    vecs.push_back('{4'b0100, 0, 8, 5, 0});
    vecs.push_back('{4'b1100, 1, 8, 6, 0});
    vecs.push_back('{4'b0110, 0, 8, 7, 0});
    vecs.push_back('{4'b0011, 0, 9, 8, 0});
    vecs.push_back('{4'b0000, 0, 9, 8, 0});
    vecs.push_back('{4'b1111, 1, 9, 9, 0});
    do_reset();
    chk_reset_vals("reset_sync");
    foreach (vecs[i]) begin
      press(vecs[i].keys);
      chk($sformatf("vec%0d.row", i),   128'(fif.frog_row), 128'(vecs[i].row));
      chk($sformatf("vec%0d.col", i),   128'(fif.frog_col), 128'(vecs[i].col));
      chk($sformatf("vec%0d.moves", i), 128'(fif.moves),    128'(vecs[i].mv));
      chk($sformatf("vec%0d.win", i),   128'(fif.win),      128'(vecs[i].w));
    end

    // ---------------- seven ups reach the goal ----------------
    do_reset();
    for (int i = 1; i <= 7; i++) begin
      press(4'b1000);
      chk($sformatf("up%0d.row", i), 128'(fif.frog_row), 128'(i));
      chk($sformatf("up%0d.win", i), 128'(fif.win),      128'(i == 7));
    end
    chk("goal.moves", 128'(fif.moves), 128'd7);
    press(4'b0100);
    press(4'b0010);
    press(4'b1000);
    chk("goal_frozen.row",   128'(fif.frog_row), 128'd7);
    chk("goal_frozen.col",   128'(fif.frog_col), 128'd7);
    chk("goal_frozen.moves", 128'(fif.moves),    128'd7);
    chk("goal_frozen.win",   128'(fif.win),      128'd1);

    // ---------------- right clamp at column 0 ----------------
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      press(4'b0001);
      chk($sformatf("right%0d.col", i), 128'(fif.frog_col), 128'((i <= 7) ? 7 - i : 0));
    end
    chk("right_clamp.moves", 128'(fif.moves), 128'd7);

    // ---------------- left clamp at column 15 ----------------
    do_reset();
    for (int i = 0; i < 9; i++) press(4'b0010);
    chk("left_clamp.col",   128'(fif.frog_col), 128'd15);
    chk("left_clamp.moves", 128'(fif.moves),    128'd8);

    // ---------------- step onto a car: hit one cycle after the move ----------------
    do_reset();
    fif.lane_pixels[1] = 16'h0080;
    fif.lane_pixels[0] = 16'hffff;
    set_keys(4'b1000);
    tick();
    chk("step_car.pre_row", 128'(fif.frog_row), 128'd0);
    tick();
    chk("step_car.row",   128'(fif.frog_row), 128'd1);
    chk("step_car.hit0",  128'(fif.hit),      128'd0);
    set_keys(4'b0000);
    tick();
    chk("step_car.hit1",  128'(fif.hit),      128'd1);
    tick();
    press(4'b1000);
    press(4'b0010);
    chk("step_car.frozen_row",   128'(fif.frog_row), 128'd1);
    chk("step_car.frozen_col",   128'(fif.frog_col), 128'd7);
    chk("step_car.frozen_moves", 128'(fif.moves),    128'd1);
    chk("step_car.frozen_hit",   128'(fif.hit),      128'd1);

    // ---------------- car arrives on a stationary frog ----------------
    do_reset();
    press(4'b1000);
    press(4'b1000);
    for (int i = 0; i < 4; i++) press(4'b0001);
    chk("park.row", 128'(fif.frog_row), 128'd2);
    chk("park.col", 128'(fif.frog_col), 128'd3);
    fif.lane_pixels[2] = 16'h0008;
    #1;
    chk("car_arrive.hit_before_edge", 128'(fif.hit), 128'd0);
    tick();
    chk("car_arrive.hit", 128'(fif.hit), 128'd1);
    chk("car_arrive.moves", 128'(fif.moves), 128'd6);

    // ---------------- simultaneous up+left ----------------
    do_reset();
    press(4'b1010);
    chk("up_left.row",   128'(fif.frog_row), 128'd1);
    chk("up_left.col",   128'(fif.frog_col), 128'd7);
    chk("up_left.moves", 128'(fif.moves),    128'd1);

    // ---------------- async reset from HIT with key_up held ----------------
    do_reset();
    fif.lane_pixels[1] = 16'h0080;
    press(4'b1000);
    chk("pre_async.hit", 128'(fif.hit), 128'd1);
    fif.key_up = 1'b1;
    tick();
    #3;
    fif.lane_pixels = '0;
    reset = 1'b1;
    #1;
    chk_reset_vals("async_from_hit");
    tick();
    tick();
    #3;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("held_key.row",   128'(fif.frog_row), 128'd0);
    chk("held_key.moves", 128'(fif.moves),    128'd0);
    fif.key_up = 1'b0;
    tick();
    tick();
    press(4'b1000);
    chk("repress.row",   128'(fif.frog_row), 128'd1);
    chk("repress.moves", 128'(fif.moves),    128'd1);

    // ---------------- moves saturate at 255 ----------------
    do_reset();
    for (int i = 0; i < 260; i++) press((i % 2 == 0) ? 4'b0010 : 4'b0001);
    chk("sat.moves", 128'(fif.moves),    128'd255);
    chk("sat.row",   128'(fif.frog_row), 128'd0);
    chk("sat.col",   128'(fif.frog_col), 128'd7);

    // ---------------- random walks against the model ----------------
    for (int ep = 0; ep < 12; ep++) begin
      do_reset();
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          m_lane[r][c] = ($urandom_range(0, 6) == 0);
      fif.lane_pixels = m_lane;
      tick();
      chk_model($sformatf("rnd%0d.start", ep));
      for (int s = 0; s < 20; s++) begin
        logic [3:0] k;
        k = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15))
                                        : 4'(1 << $urandom_range(0, 3));
        press(k);
        model_press(k);
        chk_model($sformatf("rnd%0d.s%0d", ep, s));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/frog_collision.md
FROG_COLLISION -- requirements
Module: frog_collision

Interface
REQ-001 Parameters: none; ROWS=8, COLS=16 and START_COL=7 are fixed constants from frog_pkg.
REQ-002 clk  input  1  system clock; all state changes on posedge clk.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 key_up, key_down, key_left, key_right  input  1 each  level key inputs, already synchronized to clk, high while pressed.
REQ-005 lane_pixels  input  ROWS x 16  car-lane pixel rows; row r bit c = 1 means a car occupies (r,c); rows 0 and 7 are safe rows and are ignored.
REQ-006 frog_row  output  3  current frog row, 0 = start, 7 = goal.
REQ-007 frog_col  output  4  current frog column; bit index into a lane row, 15 = leftmost.
REQ-008 frog_pixels  output  ROWS x 16  one-hot overlay with a single 1 at (frog_row, frog_col).
REQ-009 hit  output  1  high in state HIT; fans out to every car-lane block to freeze it.
REQ-010 win  output  1  high in state WIN.
REQ-011 moves  output  8  count of accepted moves, saturating at 255.

Function
REQ-012 Each key input passes through a rising-edge detector; a move request is a 1-cycle pulse on the cycle after a 0->1 transition is registered.
REQ-013 FSM states are ALIVE, HIT and WIN; reset enters ALIVE.
REQ-014 ALIVE: if lane_pixels[frog_row][frog_col]=1 and frog_row is 1..6, go to HIT next cycle; any move request that cycle is discarded.
REQ-015 ALIVE with no collision: apply at most one move per cycle with priority up > down > left > right; other simultaneous requests are dropped, not queued.
REQ-016 up: frog_row+1; down: frog_row-1; left: frog_col+1; right: frog_col-1.
REQ-017 Moves are clamped at the boundaries: down at row 0, left at col 15 and right at col 0 are ignored, and an ignored move does not increment moves.
REQ-018 An up move from row 6 sets frog_row=7 and enters WIN in the same cycle.
REQ-019 Collision is evaluated against the registered position each cycle, so a frog stepping onto a car is detected one cycle after the move, and a car moving onto a stationary frog is also detected.
REQ-020 HIT and WIN are terminal: position and moves are frozen, key inputs are ignored, and only reset exits.
REQ-021 moves increments by 1 per accepted move and holds at 255.
REQ-022 All outputs are registered or decoded purely from registered state; no combinational path from lane_pixels or the key inputs to any output.

Reset
REQ-023 Asserting reset at any time, including mid-move or in HIT or WIN, immediately forces state=ALIVE, frog_row=0, frog_col=7, moves=0, hit=0 and win=0, and clears the edge-detector history.
REQ-024 frog_pixels during reset is row 0 = 16'h0080, with all other rows 0.
REQ-025 A key already held when reset deasserts produces no move until it is released and pressed again.

Structure
REQ-026 frog_pkg holds the state enum (ALIVE, HIT, WIN) and the constants ROWS, COLS, START_COL, GOAL_ROW=7 and MOVES_MAX=255.
REQ-027 A single sub-module, edge_detect (1-bit rising-edge pulse, async active-high reset), is instantiated four times.
REQ-028 The collision mux, move logic, FSM and overlay decode live in frog_collision; the total is 120-400 lines of RTL.

Verification
REQ-029 Reset, then press key_up 7 times with lane_pixels all 0 -> frog_row steps 1..7, win=1 on the 7th accepted move, moves=7, and further keys have no effect.
REQ-030 Reset, then press key_right 8 times -> frog_col goes 7..0 and then holds at 0; moves=7.
REQ-031 Frog at (0,7) with lane_pixels[1]=16'h0080; press up -> frog_row=1 and hit=1 exactly one cycle later; position and moves are frozen.
REQ-032 Frog at (2,3) stationary, then set lane_pixels[2] bit 3 -> hit=1 on the next posedge.
REQ-033 key_up and key_left rise in the same cycle at (0,7) -> only the up move is applied: frog at (1,7), moves=1.
REQ-034 Assert reset asynchronously (between clock edges) while in HIT -> outputs return to their reset values without a clock edge; with key_up held through the reset release, no move occurs.
